// File: rtl/mem_arb.sv
// Two-port arbiter onto one single-port synchronous memory: data port has
// priority, instruction fetch is forced through after STARVE_MAX denials.
module mem_arb #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    o_dbg_state,
  output logic [1:0]    o_dbg_starve_cnt
);

  // Handshake: a requester raises req with addr/data and holds them stable
  // until it sees gnt in the same cycle; gnt is the accept. Read data returns
  // on the matching rvalid exactly one cycle after the grant, with no backpressure.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IF_RD = 2'd1,
    S_D_RD  = 2'd2
  } state_t;

  localparam logic [1:0] C_STARVE_MAX = 2'(STARVE_MAX);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_starve_cnt;
  logic [1:0] w_starve_nxt;
  logic       w_if_win;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= 2'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  always_comb begin
    w_if_win     = 1'b0;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if_rvalid    = 1'b0;
    d_rvalid     = 1'b0;
    if_rdata     = '0;
    d_rdata      = '0;
    w_state_nxt  = S_IDLE;
    w_starve_nxt = r_starve_cnt;

    if (!reset) begin
      // Fetch only wins when uncontested or once it has been starved long enough.
      w_if_win = if_req && (!d_req || (r_starve_cnt == C_STARVE_MAX));
      if_gnt   = w_if_win;
      d_gnt    = d_req && !w_if_win;

      if (if_gnt) begin
        mem_en      = 1'b1;
        mem_addr    = if_addr;
        w_state_nxt = S_IF_RD;
      end else if (d_gnt) begin
        mem_en      = 1'b1;
        mem_we      = d_we;
        mem_addr    = d_addr;
        mem_wdata   = d_wdata;
        w_state_nxt = d_we ? S_IDLE : S_D_RD;
      end

      if (!if_req || if_gnt) begin
        w_starve_nxt = 2'd0;
      end else if (r_starve_cnt < C_STARVE_MAX) begin
        w_starve_nxt = r_starve_cnt + 2'd1;
      end

      if_rvalid = (r_state == S_IF_RD);
      d_rvalid  = (r_state == S_D_RD);
      if (if_rvalid) if_rdata = mem_rdata;
      if (d_rvalid)  d_rdata  = mem_rdata;
    end
  end

  assign o_dbg_state      = r_state;
  assign o_dbg_starve_cnt = r_starve_cnt;

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter AW, 8, address width.
REQ-002 Parameter DW, 8, data width.
REQ-003 Parameter STARVE_MAX, 3, consecutive fetch denials before fetch is forced to win.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 if_req  input  1  instruction-fetch read request.
REQ-007 if_addr  input  AW  fetch address.
REQ-008 if_gnt  output  1  fetch granted this cycle.
REQ-009 if_rvalid  output  1  fetch read data valid.
REQ-010 if_rdata  output  DW  fetch read data.
REQ-011 d_req  input  1  data-port request (load/store/push/pop/vector read).
REQ-012 d_we  input  1  data request is a write.
REQ-013 d_addr  input  AW  data address.
REQ-014 d_wdata  input  DW  write data.
REQ-015 d_gnt  output  1  data request granted this cycle.
REQ-016 d_rvalid  output  1  data read data valid.
REQ-017 d_rdata  output  DW  data read data.
REQ-018 mem_en, mem_we  output  1 each  single-port memory enable / write enable.
REQ-019 mem_addr  output  AW; mem_wdata  output  DW; mem_rdata  input  DW  memory bus; read data appears one cycle after mem_en with mem_we=0.

Function
REQ-020 At most one of if_gnt/d_gnt SHALL be 1 in any cycle; grants are combinational from current requests and registered state.
REQ-021 Priority: d_req wins over if_req unless starve_cnt == STARVE_MAX, in which case if_req wins.
REQ-022 starve_cnt (2 bits, saturating at STARVE_MAX) SHALL increment each cycle if_req=1 and if_gnt=0, and clear when if_gnt=1 or if_req=0.
REQ-023 On any grant: mem_en=1, mem_addr/mem_wdata/mem_we from the granted port (mem_we=0 and mem_wdata=0 for fetch); no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-024 Owner FSM (registered) states: S_IDLE, S_IF_RD, S_D_RD; next state = S_IF_RD if if_gnt, S_D_RD if d_gnt with d_we=0, else S_IDLE (includes granted writes).
REQ-025 if_rvalid=1 exactly when state==S_IF_RD; d_rvalid=1 exactly when state==S_D_RD; read latency = 1 cycle after grant.
REQ-026 if_rdata = mem_rdata when if_rvalid else 0; d_rdata = mem_rdata when d_rvalid else 0.
REQ-027 Back-to-back grants SHALL be allowed every cycle; a new grant in the same cycle as an rvalid is legal.
REQ-028 Requesters hold req/addr/data stable until granted; an ungranted request has no side effect other than starve_cnt.
REQ-029 Write grant: memory written at the grant edge, no rvalid on either port.

Reset
REQ-030 While reset=1: if_gnt=d_gnt=0, mem_en=mem_we=0, all rvalid=0, rdata=0, regardless of requests.
REQ-031 At reset edge: state=S_IDLE, starve_cnt=0; any in-flight read is dropped (no rvalid after reset).
REQ-032 First grant possible in the first cycle with reset=0.

Verification
REQ-033 if_req only, if_addr=0x10, mem holds 0xA5 -> if_gnt=1 cycle 0, if_rvalid=1 and if_rdata=0xA5 cycle 1.
REQ-034 if_req and d_req (read 0x20) same cycle -> d_gnt=1, if_gnt=0; next cycle d_rvalid=1, if_rvalid=0.
REQ-035 if_req and d_req held high continuously, STARVE_MAX=3 -> d_gnt cycles 0-2, if_gnt cycle 3, starve_cnt back to 0, d_gnt cycle 4.
REQ-036 d_req write 0x33 to 0x05, then fetch 0x05 -> mem_we=1 only in write cycle, no rvalid after write, fetch returns 0x33.
REQ-037 Read granted, reset asserted next cycle -> no rvalid, all grants 0 during reset, state S_IDLE after release.
REQ-038 Alternating single-cycle d_req and if_req every cycle -> grants alternate, every read returns rvalid one cycle later on correct port only.
